// File: rtl/message_combiner_pkg.sv
// Shared defaults, header field widths and FSM encoding for the debug message combiner.
// Slicer and combiner both import this so the header layout stays in agreement.
package message_combiner_pkg;

  localparam int unsigned DEF_MSG_WIDTH        = 32;
  localparam int unsigned DEF_MAX_LEN          = 4;
  localparam int unsigned DEF_LENGTH_WIDTH     = 8;
  localparam int unsigned DEF_FORMATCODE_WIDTH = 4;
  localparam int unsigned DEF_MODULECODE_WIDTH = 8;
  localparam int unsigned DEF_ERRORCODE_WIDTH  = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Payload counter must reach MAX_LEN inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/message_combiner_if.sv
// Word-stream input and assembled-message output bundle of the message combiner.
interface message_combiner_if
  import message_combiner_pkg::*;
#(
  parameter int unsigned MSG_WIDTH        = DEF_MSG_WIDTH,
  parameter int unsigned MAX_LEN          = DEF_MAX_LEN,
  parameter int unsigned LENGTH_WIDTH     = DEF_LENGTH_WIDTH,
  parameter int unsigned FORMATCODE_WIDTH = DEF_FORMATCODE_WIDTH,
  parameter int unsigned MODULECODE_WIDTH = DEF_MODULECODE_WIDTH,
  parameter int unsigned ERRORCODE_WIDTH  = DEF_ERRORCODE_WIDTH
);

  logic [MSG_WIDTH-1:0]             in_data;
  logic                             in_nd;
  logic [MSG_WIDTH*(MAX_LEN+1)-1:0] out_data;
  logic                             out_nd;
  logic [LENGTH_WIDTH-1:0]          out_length;
  logic [FORMATCODE_WIDTH-1:0]      out_formatcode;
  logic [MODULECODE_WIDTH-1:0]      out_modulecode;
  logic [ERRORCODE_WIDTH-1:0]       out_errorcode;
  logic                             error;

  modport master (
    output in_data, in_nd,
    input  out_data, out_nd, out_length, out_formatcode, out_modulecode, out_errorcode, error
  );

  modport slave (
    input  in_data, in_nd,
    output out_data, out_nd, out_length, out_formatcode, out_modulecode, out_errorcode, error
  );

endinterface

// File: rtl/message_header_decode.sv
// Combinational split of a stream word into header flag and header fields.
// Fields are packed from just below the header flag downwards; leftover low bits are ignored.
module message_header_decode
  import message_combiner_pkg::*;
#(
  parameter int unsigned MSG_WIDTH        = DEF_MSG_WIDTH,
  parameter int unsigned LENGTH_WIDTH     = DEF_LENGTH_WIDTH,
  parameter int unsigned FORMATCODE_WIDTH = DEF_FORMATCODE_WIDTH,
  parameter int unsigned MODULECODE_WIDTH = DEF_MODULECODE_WIDTH,
  parameter int unsigned ERRORCODE_WIDTH  = DEF_ERRORCODE_WIDTH
) (
  input  logic [MSG_WIDTH-1:0]        word,
  output logic                        is_header_c,
  output logic [LENGTH_WIDTH-1:0]     length_c,
  output logic [FORMATCODE_WIDTH-1:0] formatcode_c,
  output logic [MODULECODE_WIDTH-1:0] modulecode_c,
  output logic [ERRORCODE_WIDTH-1:0]  errorcode_c
);

  localparam int unsigned LEN_MSB = MSG_WIDTH - 2;
  localparam int unsigned FMT_MSB = LEN_MSB - LENGTH_WIDTH;
  localparam int unsigned MOD_MSB = FMT_MSB - FORMATCODE_WIDTH;
  localparam int unsigned ERR_MSB = MOD_MSB - MODULECODE_WIDTH;
  localparam int unsigned LOW_W   = ERR_MSB + 1 - ERRORCODE_WIDTH;

  assign is_header_c  = word[MSG_WIDTH-1];
  assign length_c     = word[LEN_MSB -: LENGTH_WIDTH];
  assign formatcode_c = word[FMT_MSB -: FORMATCODE_WIDTH];
  assign modulecode_c = word[MOD_MSB -: MODULECODE_WIDTH];
  assign errorcode_c  = word[ERR_MSB -: ERRORCODE_WIDTH];

  generate
    if (LOW_W > 0) begin : g_low
      logic unused_low;
      assign unused_low = ^word[LOW_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/message_combiner.sv
// Reassembles header + payload word streams into one wide message with decoded header fields.
// Malformed streams pulse error and the block resynchronises on the next header.
module message_combiner
  import message_combiner_pkg::*;
#(
  parameter int unsigned MSG_WIDTH        = DEF_MSG_WIDTH,
  parameter int unsigned MAX_LEN          = DEF_MAX_LEN,
  parameter int unsigned LENGTH_WIDTH     = DEF_LENGTH_WIDTH,
  parameter int unsigned FORMATCODE_WIDTH = DEF_FORMATCODE_WIDTH,
  parameter int unsigned MODULECODE_WIDTH = DEF_MODULECODE_WIDTH,
  parameter int unsigned ERRORCODE_WIDTH  = DEF_ERRORCODE_WIDTH
) (
  input logic               clk,
  input logic               rst,
  message_combiner_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(MAX_LEN);
  localparam int unsigned PL_W  = MSG_WIDTH * MAX_LEN;
  localparam int unsigned OUT_W = MSG_WIDTH * (MAX_LEN + 1);

  logic                        is_header_c;
  logic [LENGTH_WIDTH-1:0]     length_c;
  logic [FORMATCODE_WIDTH-1:0] formatcode_c;
  logic [MODULECODE_WIDTH-1:0] modulecode_c;
  logic [ERRORCODE_WIDTH-1:0]  errorcode_c;

  message_header_decode #(
    .MSG_WIDTH       (MSG_WIDTH),
    .LENGTH_WIDTH    (LENGTH_WIDTH),
    .FORMATCODE_WIDTH(FORMATCODE_WIDTH),
    .MODULECODE_WIDTH(MODULECODE_WIDTH),
    .ERRORCODE_WIDTH (ERRORCODE_WIDTH)
  ) u_decode (
    .word        (bus.in_data),
    .is_header_c (is_header_c),
    .length_c    (length_c),
    .formatcode_c(formatcode_c),
    .modulecode_c(modulecode_c),
    .errorcode_c (errorcode_c)
  );

  state_e                      state_q, state_n;
  logic [CNT_W-1:0]            cnt_q, cnt_n;
  logic [MSG_WIDTH-1:0]        hdr_q, hdr_n;
  logic [LENGTH_WIDTH-1:0]     len_q, len_n;
  logic [FORMATCODE_WIDTH-1:0] fmt_q, fmt_n;
  logic [MODULECODE_WIDTH-1:0] mod_q, mod_n;
  logic [ERRORCODE_WIDTH-1:0]  err_q, err_n;
  logic [MSG_WIDTH-1:0]        buf_q [MAX_LEN];
  logic [MSG_WIDTH-1:0]        buf_n [MAX_LEN];

  logic [OUT_W-1:0]            out_data_q, out_data_n;
  logic                        out_nd_q, out_nd_n;
  logic [LENGTH_WIDTH-1:0]     out_len_q, out_len_n;
  logic [FORMATCODE_WIDTH-1:0] out_fmt_q, out_fmt_n;
  logic [MODULECODE_WIDTH-1:0] out_mod_q, out_mod_n;
  logic [ERRORCODE_WIDTH-1:0]  out_err_q, out_err_n;
  logic                        error_q, error_n;

  // Next-state, payload capture and emit decisions.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    hdr_n      = hdr_q;
    len_n      = len_q;
    fmt_n      = fmt_q;
    mod_n      = mod_q;
    err_n      = err_q;
    buf_n      = buf_q;
    out_data_n = out_data_q;
    out_len_n  = out_len_q;
    out_fmt_n  = out_fmt_q;
    out_mod_n  = out_mod_q;
    out_err_n  = out_err_q;
    out_nd_n   = 1'b0;
    error_n    = 1'b0;

    if (bus.in_nd) begin
      if (is_header_c) begin
        // A header always restarts framing; one arriving mid-message truncates it.
        if (state_q == ST_COLLECT) begin
          error_n = 1'b1;
        end
        state_n = ST_IDLE;
        cnt_n   = '0;
        if (length_c == '0) begin
          out_data_n = {bus.in_data, PL_W'(0)};
          out_len_n  = length_c;
          out_fmt_n  = formatcode_c;
          out_mod_n  = modulecode_c;
          out_err_n  = errorcode_c;
          out_nd_n   = 1'b1;
        end else if (length_c <= LENGTH_WIDTH'(MAX_LEN)) begin
          state_n = ST_COLLECT;
          hdr_n   = bus.in_data;
          len_n   = length_c;
          fmt_n   = formatcode_c;
          mod_n   = modulecode_c;
          err_n   = errorcode_c;
        end else begin
          error_n = 1'b1;
        end
      end else if (state_q == ST_IDLE) begin
        error_n = 1'b1;
      end else begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (CNT_W'(i) == cnt_q) buf_n[i] = bus.in_data;
        end
        cnt_n = cnt_q + CNT_W'(1);
        if (LENGTH_WIDTH'(cnt_q) + LENGTH_WIDTH'(1) == len_q) begin
          // Slices beyond the final word are forced to zero, so stale buffer entries never leak.
          out_data_n = '0;
          out_data_n[PL_W +: MSG_WIDTH] = hdr_q;
          for (int i = 0; i < MAX_LEN; i++) begin
            if (CNT_W'(i) < cnt_q) begin
              out_data_n[MSG_WIDTH*(MAX_LEN-1-i) +: MSG_WIDTH] = buf_q[i];
            end else if (CNT_W'(i) == cnt_q) begin
              out_data_n[MSG_WIDTH*(MAX_LEN-1-i) +: MSG_WIDTH] = bus.in_data;
            end
          end
          out_len_n = len_q;
          out_fmt_n = fmt_q;
          out_mod_n = mod_q;
          out_err_n = err_q;
          out_nd_n  = 1'b1;
          state_n   = ST_IDLE;
          cnt_n     = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      len_q      <= '0;
      fmt_q      <= '0;
      mod_q      <= '0;
      err_q      <= '0;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      out_len_q  <= '0;
      out_fmt_q  <= '0;
      out_mod_q  <= '0;
      out_err_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      hdr_q      <= hdr_n;
      len_q      <= len_n;
      fmt_q      <= fmt_n;
      mod_q      <= mod_n;
      err_q      <= err_n;
      buf_q      <= buf_n;
      out_data_q <= out_data_n;
      out_nd_q   <= out_nd_n;
      out_len_q  <= out_len_n;
      out_fmt_q  <= out_fmt_n;
      out_mod_q  <= out_mod_n;
      out_err_q  <= out_err_n;
      error_q    <= error_n;
    end
  end

  assign bus.out_data       = out_data_q;
  assign bus.out_nd         = out_nd_q;
  assign bus.out_length     = out_len_q;
  assign bus.out_formatcode = out_fmt_q;
  assign bus.out_modulecode = out_mod_q;
  assign bus.out_errorcode  = out_err_q;
  assign bus.error          = error_q;

endmodule

// File: tb/tb_message_combiner.sv
// Directed bench for message_combiner: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_message_combiner;

  logic clk = 1'b0;
  logic rst;

  message_combiner_if #(
    .MSG_WIDTH(32), .MAX_LEN(4), .LENGTH_WIDTH(8),
    .FORMATCODE_WIDTH(4), .MODULECODE_WIDTH(8), .ERRORCODE_WIDTH(8)
  ) bus ();

  message_combiner #(
    .MSG_WIDTH(32), .MAX_LEN(4), .LENGTH_WIDTH(8),
    .FORMATCODE_WIDTH(4), .MODULECODE_WIDTH(8), .ERRORCODE_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int nd_cnt   = 0;
  int err_cnt  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames the word stream with a queue and predicts next-cycle outputs.
  logic [159:0] exp_data;
  logic [7:0]   exp_len, exp_mod, exp_ecode;
  logic [3:0]   exp_fmt;
  logic         exp_nd, exp_err;
  logic [31:0]  m_hdr, w;
  logic [31:0]  pl [$];
  bit           in_msg;
  int           want, l;

  task automatic emit(input logic [31:0] h);
    exp_data = {h, 128'b0};
    foreach (pl[i]) exp_data = exp_data | (160'(pl[i]) << (32 * (3 - i)));
    exp_len   = 8'((h >> 23) & 32'hFF);
    exp_fmt   = 4'((h >> 19) & 32'hF);
    exp_mod   = 8'((h >> 11) & 32'hFF);
    exp_ecode = 8'((h >> 3) & 32'hFF);
    exp_nd    = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_nd  = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      exp_data = '0; exp_len = '0; exp_fmt = '0; exp_mod = '0; exp_ecode = '0;
      in_msg = 1'b0;
      pl.delete();
    end else if (bus.in_nd) begin
      w = bus.in_data;
      if (w[31]) begin
        if (in_msg) begin
          exp_err = 1'b1;
          in_msg  = 1'b0;
        end
        l = int'((w >> 23) & 32'hFF);
        if (l == 0) begin
          pl.delete();
          emit(w);
        end else if (l <= 4) begin
          m_hdr  = w;
          want   = l;
          pl.delete();
          in_msg = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end else if (!in_msg) begin
        exp_err = 1'b1;
      end else begin
        pl.push_back(w);
        if (pl.size() == want) begin
          emit(m_hdr);
          in_msg = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_nd", 160'(bus.out_nd), 160'(exp_nd));
      check("error", 160'(bus.error), 160'(exp_err));
      check("out_data", bus.out_data, exp_data);
      check("out_length", 160'(bus.out_length), 160'(exp_len));
      check("out_formatcode", 160'(bus.out_formatcode), 160'(exp_fmt));
      check("out_modulecode", 160'(bus.out_modulecode), 160'(exp_mod));
      check("out_errorcode", 160'(bus.out_errorcode), 160'(exp_ecode));
      if (bus.out_nd === 1'b1) nd_cnt++;
      if (bus.error === 1'b1) err_cnt++;
    end
  end

  task automatic send(input logic [31:0] word);
    bus.in_data = word;
    bus.in_nd   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_nd   = 1'b0;
    bus.in_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int nd0, er0;

  initial begin
    rst = 1'b1;
    bus.in_nd = 1'b0;
    bus.in_data = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    idle(1);
    check("reset_out_data", bus.out_data, 160'h0);
    check("reset_out_nd", 160'(bus.out_nd), 160'h0);
    check("reset_error", 160'(bus.error), 160'h0);
    rst = 1'b0;
    idle(1);

    // 1: length-1 message
    nd0 = nd_cnt;
    send(32'h8080_0000);
    send(32'h0000_1234);
    check("t1_nd", 160'(bus.out_nd), 160'h1);
    check("t1_len", 160'(bus.out_length), 160'h1);
    check("t1_data", bus.out_data, 160'h80800000_00001234_00000000_00000000_00000000);
    idle(2);
    check("t1_hold", bus.out_data, 160'h80800000_00001234_00000000_00000000_00000000);

    // 2: length-0 header emits immediately
    send(32'h8000_2800);
    check("t2_nd", 160'(bus.out_nd), 160'h1);
    check("t2_mod", 160'(bus.out_modulecode), 160'h5);
    check("t2_data", bus.out_data, 160'h80002800_00000000_00000000_00000000_00000000);
    idle(1);

    // 3: truncated message then a complete one
    nd0 = nd_cnt; er0 = err_cnt;
    send(32'h8100_0000);
    send(32'h0000_0001);
    send(32'h8080_0000);
    check("t3_err", 160'(bus.error), 160'h1);
    send(32'h0000_0002);
    idle(1);
    check("t3_nd_count", 160'(nd_cnt - nd0), 160'h1);
    check("t3_err_count", 160'(err_cnt - er0), 160'h1);
    check("t3_data", bus.out_data, 160'h80800000_00000002_00000000_00000000_00000000);
    check("t3_len", 160'(bus.out_length), 160'h1);

    // 4: stray payload, oversize header, and its stray payload
    nd0 = nd_cnt; er0 = err_cnt;
    send(32'h0000_0055);
    send(32'h8280_0000);
    for (int i = 0; i < 5; i++) send(32'(i + 16));
    idle(1);
    check("t4_err_count", 160'(err_cnt - er0), 160'd7);
    check("t4_nd_count", 160'(nd_cnt - nd0), 160'h0);

    // 5: reset mid-message
    nd0 = nd_cnt; er0 = err_cnt;
    send(32'h8180_0000);
    send(32'h0000_0077);
    rst = 1'b1;
    idle(1);
    check("t5_rst_data", bus.out_data, 160'h0);
    check("t5_rst_len", 160'(bus.out_length), 160'h0);
    check("t5_rst_err", 160'(bus.error), 160'h0);
    rst = 1'b0;
    send(32'h8000_0000);
    idle(1);
    check("t5_nd_count", 160'(nd_cnt - nd0), 160'h1);
    check("t5_err_count", 160'(err_cnt - er0), 160'h0);
    check("t5_data", bus.out_data, 160'h80000000_00000000_00000000_00000000_00000000);

    // 6: idle gaps between payload words
    send(32'h8100_0000);
    send(32'h0000_000A);
    idle(3);
    send(32'h0000_000B);
    check("t6_nd", 160'(bus.out_nd), 160'h1);
    check("t6_data", bus.out_data, 160'h81000000_0000000A_0000000B_00000000_00000000);

    // 7: truncating length-0 header pulses both, fields decoded; then full 4-word message
    send(32'h8180_0000);
    send(32'h0000_0003);
    send(32'h8000_0000 | (32'h9 << 19) | (32'hA5 << 3));
    check("t7_both_nd", 160'(bus.out_nd), 160'h1);
    check("t7_both_err", 160'(bus.error), 160'h1);
    check("t7_fmt", 160'(bus.out_formatcode), 160'h9);
    check("t7_ecode", 160'(bus.out_errorcode), 160'hA5);
    send(32'h8200_0000);
    send(32'h1); send(32'h2); send(32'h3); send(32'h4);
    check("t7_full", bus.out_data, 160'h82000000_00000001_00000002_00000003_00000004);
    send(32'h8000_0000);
    send(32'h8000_0800);
    check("t7_b2b_mod", 160'(bus.out_modulecode), 160'h1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
